dpram_rd_arbiter: RTL

- Round-robin arbiter that shares the single read port (enb/addrb/dob) of one dpram_wrapper instance between NREQ read requesters, e.g. conv row fetcher, pooling unit and debug readout.
- Tracks the RAM read latency (N_DELAY) with a tag pipeline and returns read data to the correct requester with a one-hot valid.
- Sits between the requester engines and the RAM; the RAM write port is not touched.

---
 rtl/dpram_rd_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dpram_rd_arbiter.sv
// dpram_rd_arbiter: round-robin sharing of one dpram read port (enb/addrb/dob)
// among NREQ read requesters. A tag pipeline of depth N_DELAY follows each
// read through the RAM and steers the returning data to its requester.
// Optional build macro: RD_ARB_PERF_EN adds grant and stall counters.
module dpram_rd_arbiter #(
    parameter int DW      = 32,
    parameter int AW      = 16,
    parameter int NREQ    = 3,
    parameter int N_DELAY = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      rd_req,
    input  logic [NREQ*AW-1:0]   rd_addr,
    output logic [NREQ-1:0]      rd_gnt,
    output logic [NREQ-1:0]      rd_vld,
    output logic [DW-1:0]        rd_data,
    output logic                 ram_enb,
    output logic [AW-1:0]        ram_addrb,
    input  logic [DW-1:0]        ram_dob,
    output logic [NREQ*32-1:0]   perf_gnt_cnt,
    output logic [31:0]          perf_stall_cnt
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] rr_ptr;
    logic          gnt_any;
    logic [IW-1:0] gnt_idx;
    logic [AW-1:0] last_addr;
    logic          vld_p [N_DELAY];
    logic [IW-1:0] idx_p [N_DELAY];

    // Round-robin search from rr_ptr, wrapping; no grant while in reset.
    always_comb begin
        int j;
        j       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(rr_ptr) + k) % NREQ;
            if (rstn && !gnt_any && rd_req[j[IW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = j[IW-1:0];
            end
        end
    end

    // One-hot grant decode.
    always_comb begin
        rd_gnt = '0;
        if (gnt_any) rd_gnt[gnt_idx] = 1'b1;
    end

    // Pointer moves just past the winner; holds when nothing is granted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Remember the last granted address so addrb stays put while draining.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_addr <= '0;
        end else if (gnt_any) begin
            last_addr <= rd_addr[gnt_idx*AW +: AW];
        end
    end

    assign ram_addrb = gnt_any ? rd_addr[gnt_idx*AW +: AW] : last_addr;

    // Tag pipeline: stage 0 captures this cycle's grant, later stages shift.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < N_DELAY; s++) begin
                vld_p[s] <= 1'b0;
                idx_p[s] <= '0;
            end
        end else begin
            // stage 0 boundary: grant -> first tag slot
            vld_p[0] <= gnt_any;
            idx_p[0] <= gnt_idx;
            // stage s-1 -> stage s boundary
            for (int s = 1; s < N_DELAY; s++) begin
                vld_p[s] <= vld_p[s-1];
                idx_p[s] <= idx_p[s-1];
            end
        end
    end

    // The RAM delay line only advances with enb high, so keep it high until
    // every in-flight read has reached the last tag stage.
    always_comb begin
        ram_enb = gnt_any;
        for (int s = 0; s < N_DELAY - 1; s++) begin
            ram_enb = ram_enb | vld_p[s];
        end
    end

    // Last tag stage selects which requester owns the data on dob.
    always_comb begin
        rd_vld = '0;
        if (vld_p[N_DELAY-1]) rd_vld[idx_p[N_DELAY-1]] = 1'b1;
    end

    assign rd_data = ram_dob;

`ifdef RD_ARB_PERF_EN
    logic [31:0] gnt_cnt [NREQ];
    logic [31:0] stall_cnt;

    // Grant counter per requester and a count of cycles with a waiting requester.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREQ; i++) gnt_cnt[i] <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (rd_gnt[i]) gnt_cnt[i] <= gnt_cnt[i] + 32'd1;
            end
            if (|(rd_req & ~rd_gnt)) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    // Flatten the counters onto the output bus.
    always_comb begin
        perf_gnt_cnt = '0;
        for (int i = 0; i < NREQ; i++) perf_gnt_cnt[i*32 +: 32] = gnt_cnt[i];
    end

    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_gnt_cnt   = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule
